// File: rtl/dkong_scandoubler.sv
// Line-doubling scan converter: captures each input video line into one of two
// banks and replays it twice at double pixel rate with its own hsync.
module dkong_scandoubler #(
  parameter int LINE_W      = 256,
  parameter int OUT_DIV     = 5,
  parameter int OUT_HTOTAL  = 384,
  parameter int OUT_HACTIVE = 256,
  parameter int HS_START    = 288,
  parameter int HS_WIDTH    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic       pix_valid,
  input  logic       vblk_in,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [1:0] b_in,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [1:0] b_out,
  output logic       de_out,
  output logic       hsync_n,
  output logic       vblk_out,
  output logic       sync_err
);

  localparam int AW = $clog2(LINE_W);
  localparam int LW = $clog2(LINE_W + 1);
  localparam int HW = $clog2(OUT_HTOTAL);
  localparam int DW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2} state_t;

  logic [7:0]    mem [2*LINE_W];
  logic          wbank, rbank;
  logic [LW-1:0] waddr, wlen;
  logic          prev_valid;
  logic          line_done;
  logic          wr_en;
  logic [DW-1:0] div;
  logic          out_ce;
  logic [HW-1:0] hcnt;
  logic          hcnt_last;
  state_t        state, state_nxt;
  logic          show, pix_ok, in_hs;
  logic [7:0]    rd_pix;

  // A falling pix_valid only closes a line if at least one pixel was captured.
  assign line_done = prev_valid & ~pix_valid & (waddr != '0);
  assign wr_en     = pix_ce & pix_valid & (waddr < LW'(LINE_W));
  assign out_ce    = (div == '0);
  assign hcnt_last = (hcnt == HW'(OUT_HTOTAL - 1));

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wbank, waddr[AW-1:0]}] <= {r_in, g_in, b_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      waddr      <= '0;
      wlen       <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= pix_valid;
      if (line_done) begin
        wlen  <= waddr;
        rbank <= wbank;
        wbank <= ~wbank;
        waddr <= '0;
      end else if (wr_en) begin
        waddr <= waddr + LW'(1);
      end
    end
  end

  // Output timebase restarts on every completed input line so replay is line-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      hcnt <= '0;
    end else if (line_done) begin
      div  <= '0;
      hcnt <= '0;
    end else begin
      div <= (div == DW'(OUT_DIV - 1)) ? '0 : div + DW'(1);
      if (out_ce)
        hcnt <= hcnt_last ? '0 : hcnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (line_done) begin
      state_nxt = PASS1;
    end else if (out_ce && hcnt_last) begin
      case (state)
        PASS1:   state_nxt = PASS2;
        PASS2:   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    show   = (state != IDLE) && (hcnt < HW'(OUT_HACTIVE)) && !vblk_out;
    pix_ok = show && (int'(hcnt) < int'(wlen));
    in_hs  = (hcnt >= HW'(HS_START)) && (hcnt < HW'(HS_START + HS_WIDTH));
    rd_pix = mem[{rbank, hcnt[AW-1:0]}];
  end

  // Outputs are registered on out_ce and then held for the whole output pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_out, g_out, b_out} <= '0;
      de_out   <= 1'b0;
      hsync_n  <= 1'b1;
      vblk_out <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= line_done && (state == PASS1);
      if (line_done)
        vblk_out <= vblk_in;
      if (out_ce) begin
        {r_out, g_out, b_out} <= pix_ok ? rd_pix : 8'h00;
        de_out  <= show;
        hsync_n <= ~in_hs;
      end
    end
  end

endmodule

// File: tb/tb_dkong_scandoubler.sv
// Self-checking bench for dkong_scandoubler: a timeline model derives every output
// from the last completed line and the elapsed output-pixel count.
module tb_dkong_scandoubler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_ce = 1'b0, pix_valid = 1'b0, vblk_in = 1'b0;
  logic [2:0] r_in = '0, g_in = '0;
  logic [1:0] b_in = '0;
  logic [2:0] r_out, g_out;
  logic [1:0] b_out;
  logic       de_out, hsync_n, vblk_out, sync_err;

  dkong_scandoubler dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pix_valid(pix_valid), .vblk_in(vblk_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .de_out(de_out), .hsync_n(hsync_n), .vblk_out(vblk_out), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_pulses = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  // Model: line store, the line being replayed, and the time anchor of the output timebase.
  logic [7:0] m_line[$];
  logic [7:0] m_buf[256];
  int         m_wlen = 0;
  logic       m_prev_valid = 1'b0;
  longint     cyc = 0, anchor = 0, m_el, m_j;
  int         base_pass = 2, m_h, m_p;
  bit         in_reset = 1'b1, m_ld, m_act;
  logic [7:0] e_rgb = 8'h00;
  logic       e_de = 1'b0, e_hs = 1'b1, e_vblk = 1'b0, e_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_line.delete();
      m_prev_valid = 1'b0;
      m_wlen = 0;
      base_pass = 2;
      in_reset = 1'b1;
      e_rgb = 8'h00; e_de = 1'b0; e_hs = 1'b1; e_vblk = 1'b0; e_err = 1'b0;
    end else begin
      cyc++;
      if (in_reset) begin
        anchor = cyc - 1;
        in_reset = 1'b0;
      end
      m_el = cyc - anchor - 1;
      // output pixel slot j: hcnt = j mod 384, pass 0/1 replay, 2+ idle
      if (m_el >= 0 && (m_el % 5) == 0) begin
        m_j   = m_el / 5;
        m_h   = int'(m_j % 384);
        m_p   = (m_j / 384 > 2) ? 2 : base_pass + int'(m_j / 384);
        m_act = (m_p < 2) && (m_h < 256) && !e_vblk;
        e_de  = m_act;
        e_rgb = (m_act && m_h < m_wlen) ? m_buf[m_h] : 8'h00;
        e_hs  = !(m_h >= 288 && m_h < 320);
      end
      m_ld  = m_prev_valid && !pix_valid && (m_line.size() != 0);
      e_err = 1'b0;
      if (m_ld) begin
        e_err = (base_pass == 0) && (m_el >= 0) && (m_el <= 5 * 383);
        foreach (m_line[i]) m_buf[i] = m_line[i];
        m_wlen = m_line.size();
        m_line.delete();
        e_vblk = vblk_in;
        anchor = cyc;
        base_pass = 0;
      end else if (pix_ce && pix_valid && m_line.size() < 256) begin
        m_line.push_back({r_in, g_in, b_in});
      end
      m_prev_valid = pix_valid;
    end
  end

  always @(negedge clk) begin
    checkOutput("cycle", {20'h0, r_out, g_out, b_out, de_out, hsync_n, vblk_out, sync_err},
                {20'h0, e_rgb, e_de, e_hs, e_vblk, e_err});
    if (sync_err === 1'b1) err_pulses++;
  end

  task automatic applyStimulus(input int n_pix, input bit rand_pix, input bit vblk);
    vblk_in = vblk;
    for (int i = 0; i < n_pix; i++) begin
      logic [7:0] v;
      v = rand_pix ? 8'($urandom) : 8'(i);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        pix_valid = 1'b1;
        pix_ce = (k == 0);
        {r_in, g_in, b_in} = v;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_ce = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_ce = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int lows;
  int err_base;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_state", {20'h0, r_out, g_out, b_out, de_out, hsync_n, sync_err, vblk_out},
                   {20'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #2 rst_n = 1'b1;
    idle(20);

    // nominal 256-pixel ramp
    applyStimulus(256, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 checkOutput("nom_first_de", {de_out, r_out, g_out, b_out}, {1'b1, 8'd0});
    repeat (5) @(negedge clk);
    #1 checkOutput("nom_pix1", {de_out, r_out, g_out, b_out}, {1'b1, 8'd1});
    repeat (995) @(negedge clk);
    #1 checkOutput("nom_pix200", {de_out, r_out, g_out, b_out}, {1'b1, 8'd200});
    repeat (945) @(negedge clk);
    #1 checkOutput("nom_pass2_pix5", {de_out, r_out, g_out, b_out}, {1'b1, 8'd5});
    idle(2200);

    lows = 0;
    repeat (1920) begin
      @(negedge clk);
      #1 if (hsync_n === 1'b0) lows++;
    end
    checkOutput("hsync_low_clk", lows, 160);

    // short line pads black
    applyStimulus(100, 1'b1, 1'b0);
    repeat (752) @(negedge clk);
    #1 checkOutput("short_pad150", {de_out, r_out, g_out, b_out}, {1'b1, 8'd0});
    idle(3200);

    // falling pix_valid with nothing captured
    @(negedge clk); pix_valid = 1'b1;
    repeat (2) @(negedge clk); pix_valid = 1'b0;
    idle(20);

    // overrun: second line completes while still in the first replay
    err_base = err_pulses;
    applyStimulus(60, 1'b1, 1'b0);
    idle(400);
    applyStimulus(60, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1 checkOutput("overrun_restart_de", de_out, 1'b1);
    idle(10);
    checkOutput("overrun_pulses", err_pulses - err_base, 1);
    idle(4000);

    // long line during vblank
    applyStimulus(300, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1 checkOutput("vblank_out", {vblk_out, de_out}, {1'b1, 1'b0});
    vblk_in = 1'b0;
    idle(4000);

    // asynchronous reset in the middle of a line
    fork
      applyStimulus(200, 1'b1, 1'b0);
      begin
        repeat (1000) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async", {20'h0, r_out, g_out, b_out, de_out, hsync_n, sync_err},
                       {20'h0, 8'h00, 1'b0, 1'b1, 1'b0});
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    idle(4000);

    // randomized lines, lengths, blanking and spacing
    for (int t = 0; t < 4; t++) begin
      applyStimulus(int'($urandom_range(1, 300)), 1'b1, ($urandom_range(0, 3) == 0));
      vblk_in = 1'b0;
      idle(int'($urandom_range(200, 3500)));
    end
    idle(4000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
